// File: rtl/map_pkg.sv
// map_pkg: map geometry, tile codes and sequencer states
// shared by the map sequencer and its arbiter.
package map_pkg;

  localparam int MAP_W   = 20;
  localparam int MAP_H   = 15;
  localparam int N_CELLS = MAP_W * MAP_H;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    WALL  = 3'd1,
    BRICK = 3'd2,
    BASE1 = 3'd3,
    BASE2 = 3'd4,
    STEEL = 3'd5,
    WATER = 3'd6
  } tile_e;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SERVE,
    S_BLANK,
    S_WON
  } state_e;

  // Out-of-range indices land in the last-row test and count as border.
  function automatic logic on_border(input logic [8:0] idx);
    logic [8:0] col;
    col = idx % 9'(MAP_W);
    return (idx < 9'(MAP_W))
        || (idx >= 9'(N_CELLS - MAP_W))
        || (col == 9'd0)
        || (col == 9'(MAP_W - 1));
  endfunction

  function automatic logic clearable(input logic [8:0] idx);
    return (idx < 9'(N_CELLS)) && !on_border(idx);
  endfunction

endpackage

// File: rtl/map_sequencer_if.sv
// map_sequencer_if: clear handshakes, game events, level ROM
// read port and map RAM write port of the map sequencer.
interface map_sequencer_if;

  logic       clr_req1;
  logic       clr_req2;
  logic [8:0] clr_idx1;
  logic [8:0] clr_idx2;
  logic       clr_ack1;
  logic       clr_ack2;
  logic       win1;
  logic       win2;
  logic       level_next;
  logic [9:0] rom_addr;
  logic [2:0] rom_data;
  logic       map_we;
  logic [8:0] map_waddr;
  logic [2:0] map_wdata;
  logic [1:0] level;
  logic       busy;
  logic       loaded;

  modport master (
    output clr_req1, clr_req2,
    output clr_idx1, clr_idx2,
    input  clr_ack1, clr_ack2,
    output win1, win2, level_next,
    input  rom_addr,
    output rom_data,
    input  map_we, map_waddr, map_wdata,
    input  level, busy, loaded
  );

  modport slave (
    input  clr_req1, clr_req2,
    input  clr_idx1, clr_idx2,
    output clr_ack1, clr_ack2,
    input  win1, win2, level_next,
    output rom_addr,
    input  rom_data,
    output map_we, map_waddr, map_wdata,
    output level, busy, loaded
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; the player
// that won the last contended grant drops to low priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio2_q;

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = prio2_q ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

  // Pointer only moves when both players actually contended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio2_q <= 1'b0;
    end else if (req_i == 2'b11) begin
      prio2_q <= ~prio2_q;
    end
  end

endmodule

// File: rtl/map_sequencer.sv
// map_sequencer: loads levels from ROM into the map RAM, serves
// tile clears from two players and blanks the map on a win.
module map_sequencer
  import map_pkg::*;
#(
  parameter int N_LEVELS = 3
) (
  input logic            clk,
  input logic            rst_n,
  map_sequencer_if.slave sq
);

  state_e     state_q;
  logic [8:0] cnt_q;
  logic [1:0] level_q;
  logic       pend_q;
  logic [9:0] rom_addr_q;
  logic       we_q;
  logic [8:0] waddr_q;
  tile_e      wdata_q;
  logic       ack1_q;
  logic       ack2_q;
  logic       loaded_q;
  logic       busy_q;

  logic [1:0] level_d;
  logic [9:0] base_d;
  logic       load_go;
  logic       clr_ok;
  logic [1:0] req;
  logic [1:0] gnt;

  assign level_d = (level_q == 2'(N_LEVELS - 1))
                 ? 2'd0 : level_q + 2'd1;
  assign base_d  = 10'(level_d) * 10'(N_CELLS);

  assign load_go = ((state_q == S_SERVE) || (state_q == S_WON))
                && (pend_q || sq.level_next);
  assign clr_ok  = (state_q == S_SERVE) && !load_go
                && !(sq.win1 || sq.win2);

  // A player still seeing its ack is not eligible this cycle.
  assign req = clr_ok
             ? {sq.clr_req2 & ~ack2_q, sq.clr_req1 & ~ack1_q}
             : 2'b00;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      level_q    <= '0;
      pend_q     <= 1'b0;
      rom_addr_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= EMPTY;
      ack1_q     <= 1'b0;
      ack2_q     <= 1'b0;
      loaded_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      we_q     <= 1'b0;
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      loaded_q <= 1'b0;
      if (sq.level_next &&
          ((state_q == S_LOAD) || (state_q == S_BLANK))) begin
        pend_q <= 1'b1;
      end
      if (load_go) begin
        state_q    <= S_LOAD;
        level_q    <= level_d;
        rom_addr_q <= base_d;
        cnt_q      <= '0;
        pend_q     <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        unique case (state_q)
          S_LOAD: begin
            cnt_q <= cnt_q + 9'd1;
            if (cnt_q < 9'(N_CELLS - 1)) begin
              rom_addr_q <= rom_addr_q + 10'd1;
            end
            // ROM data lags the address by one cycle.
            if (cnt_q != 9'd0) begin
              we_q    <= 1'b1;
              waddr_q <= cnt_q - 9'd1;
              wdata_q <= tile_e'(sq.rom_data);
            end
            if (cnt_q == 9'(N_CELLS)) begin
              state_q  <= S_SERVE;
              loaded_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
          S_SERVE: begin
            if (sq.win1 || sq.win2) begin
              state_q <= S_BLANK;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else if (gnt[0]) begin
              ack1_q  <= 1'b1;
              we_q    <= clearable(sq.clr_idx1);
              waddr_q <= sq.clr_idx1;
              wdata_q <= EMPTY;
            end else if (gnt[1]) begin
              ack2_q  <= 1'b1;
              we_q    <= clearable(sq.clr_idx2);
              waddr_q <= sq.clr_idx2;
              wdata_q <= EMPTY;
            end
          end
          S_BLANK: begin
            we_q    <= 1'b1;
            waddr_q <= cnt_q;
            wdata_q <= on_border(cnt_q) ? WALL : EMPTY;
            cnt_q   <= cnt_q + 9'd1;
            if (cnt_q == 9'(N_CELLS - 1)) begin
              state_q <= S_WON;
              busy_q  <= 1'b0;
            end
          end
          S_WON: begin
          end
          default: begin
            state_q <= S_LOAD;
          end
        endcase
      end
    end
  end

  assign sq.clr_ack1  = ack1_q;
  assign sq.clr_ack2  = ack2_q;
  assign sq.rom_addr  = rom_addr_q;
  assign sq.map_we    = we_q;
  assign sq.map_waddr = waddr_q;
  assign sq.map_wdata = wdata_q;
  assign sq.level     = level_q;
  assign sq.busy      = busy_q;
  assign sq.loaded    = loaded_q;

endmodule

// File: tb/tb_map_sequencer.sv
// tb_map_sequencer: scoreboard bench for map_sequencer with a
// behavioural level ROM and a queue of expected map writes.
module tb_map_sequencer;

  localparam int NC = 300;

  typedef struct packed {
    logic [8:0] a;
    logic [2:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  bit   p2_prio;
  wr_t  wq[$];

  map_sequencer_if bus();

  map_sequencer #(.N_LEVELS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input int a);
    return 3'((a * 5 + a / 7) % 7);
  endfunction

  function automatic bit border_m(input int i);
    return (i / 20 == 0) || (i / 20 == 14)
        || (i % 20 == 0) || (i % 20 == 19);
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int a, input logic [2:0] d);
    wr_t e;
    e.a = 9'(a);
    e.d = d;
    wq.push_back(e);
  endtask

  task automatic push_clr(input int idx);
    if (idx < NC && !border_m(idx)) push(idx, 3'd0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.map_we) begin
      if (wq.size() == 0) begin
        chk("wr_unexp", 32'(bus.map_waddr), 32'hffff);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(bus.map_waddr), 32'(e.a));
        chk("wr_data", 32'(bus.map_wdata), 32'(e.d));
      end
    end
  end

  task automatic drain();
    @(negedge clk);
    chk("q_empty", 32'(wq.size()), 32'd0);
  endtask

  task automatic expect_load(input int lvl, input int nxt_at,
                             input int win_at);
    for (int c = 0; c < NC; c++) push(c, rom_fn(lvl * NC + c));
    chk("load_lvl", 32'(bus.level), 32'(lvl));
    for (int k = 0; k <= NC; k++) begin
      if (k < NC) chk("rom_addr", 32'(bus.rom_addr), 32'(lvl * NC + k));
      chk("load_busy", 32'(bus.busy), 32'd1);
      chk("load_pulse", 32'(bus.loaded), 32'd0);
      bus.level_next = (nxt_at >= 0) && (k == nxt_at || k == nxt_at + 2);
      bus.win1 = (win_at >= 0) && (k == win_at);
      @(negedge clk);
    end
    bus.level_next = 1'b0;
    bus.win1 = 1'b0;
    chk("loaded", 32'(bus.loaded), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic clr_pair(input int i1, input int i2);
    bit f2;
    f2 = p2_prio;
    bus.clr_idx1 = 9'(i1);
    bus.clr_idx2 = 9'(i2);
    bus.clr_req1 = 1'b1;
    bus.clr_req2 = 1'b1;
    if (f2) begin push_clr(i2); push_clr(i1); end
    else    begin push_clr(i1); push_clr(i2); end
    @(negedge clk);
    chk("pair_ack1_a", 32'(bus.clr_ack1), 32'(!f2));
    chk("pair_ack2_a", 32'(bus.clr_ack2), 32'(f2));
    if (f2) bus.clr_req2 = 1'b0;
    else    bus.clr_req1 = 1'b0;
    @(negedge clk);
    chk("pair_ack1_b", 32'(bus.clr_ack1), 32'(f2));
    chk("pair_ack2_b", 32'(bus.clr_ack2), 32'(!f2));
    bus.clr_req1 = 1'b0;
    bus.clr_req2 = 1'b0;
    p2_prio = !p2_prio;
    @(negedge clk);
    chk("pair_idle", 32'({bus.clr_ack1, bus.clr_ack2}), 32'd0);
  endtask

  task automatic clr_one(input int pl, input int idx);
    bit seen;
    seen = 1'b0;
    if (pl == 1) begin bus.clr_idx1 = 9'(idx); bus.clr_req1 = 1'b1; end
    else         begin bus.clr_idx2 = 9'(idx); bus.clr_req2 = 1'b1; end
    push_clr(idx);
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = (pl == 1) ? bus.clr_ack1 : bus.clr_ack2;
    end
    chk("one_ack", 32'(seen), 32'd1);
    @(negedge clk);
    chk("one_once", 32'((pl == 1) ? bus.clr_ack1 : bus.clr_ack2), 32'd0);
    bus.clr_req1 = 1'b0;
    bus.clr_req2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_we", 32'(bus.map_we), 32'd0);
    chk("rst_waddr", 32'(bus.map_waddr), 32'd0);
    chk("rst_wdata", 32'(bus.map_wdata), 32'd0);
    chk("rst_acks", 32'({bus.clr_ack1, bus.clr_ack2}), 32'd0);
    chk("rst_loaded", 32'(bus.loaded), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_t[6];
    int pl_t[6];
    int n;
    bit seen;
    idx_t = '{0, 310, 21, 59, 40, 278};
    pl_t  = '{1, 1, 2, 2, 1, 2};
    clk = 1'b0;
    rst_n = 1'b0;
    n_vec = 0;
    n_err = 0;
    p2_prio = 1'b0;
    bus.clr_req1 = 1'b0;
    bus.clr_req2 = 1'b0;
    bus.clr_idx1 = '0;
    bus.clr_idx2 = '0;
    bus.win1 = 1'b0;
    bus.win2 = 1'b0;
    bus.level_next = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst_n = 1'b1;

    expect_load(0, 150, 50);
    @(negedge clk);
    expect_load(1, -1, -1);
    drain();

    clr_pair(45, 46);
    clr_pair(45, 46);
    clr_pair(100, 100);
    for (int i = 0; i < 6; i++) clr_one(pl_t[i], idx_t[i]);
    drain();

    bus.win2 = 1'b1;
    for (int c = 0; c < NC; c++) push(c, border_m(c) ? 3'd1 : 3'd0);
    @(negedge clk);
    bus.win2 = 1'b0;
    n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("blank_len", 32'(n), 32'd300);
    bus.clr_idx1 = 9'd50;
    bus.clr_req1 = 1'b1;
    bus.win1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.win1 = 1'b0;
      seen = seen | bus.clr_ack1;
    end
    chk("won_noack", 32'(seen), 32'd0);
    chk("won_busy", 32'(bus.busy), 32'd0);
    chk("won_q", 32'(wq.size()), 32'd0);
    bus.level_next = 1'b1;
    @(negedge clk);
    expect_load(2, -1, -1);
    push_clr(50);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = bus.clr_ack1;
    end
    chk("held_ack", 32'(seen), 32'd1);
    bus.clr_req1 = 1'b0;
    drain();

    bus.level_next = 1'b1;
    @(negedge clk);
    expect_load(0, -1, -1);
    drain();
    bus.level_next = 1'b1;
    @(negedge clk);
    expect_load(1, -1, -1);
    drain();

    bus.win1 = 1'b1;
    for (int c = 0; c < 120; c++) push(c, border_m(c) ? 3'd1 : 3'd0);
    @(negedge clk);
    bus.win1 = 1'b0;
    repeat (120) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    chk("pre_rst_q", 32'(wq.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_load(0, -1, -1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
